// File: rtl/sme_pkg.sv
// sme_pkg: shared sizes, special chars, FSM states and stored-pattern layout for the pattern bank
package sme_pkg;
    localparam int MAX_LEN = 8;
    localparam int NUM_PAT = 4;
    localparam int CHAR_W = 8;
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int SEL_W = $clog2(NUM_PAT);
    localparam int IDX_W = $clog2(MAX_LEN);
    localparam logic [CHAR_W-1:0] CHAR_CARET = 8'h5E;
    localparam logic [CHAR_W-1:0] CHAR_DOLLAR = 8'h24;
    localparam logic [CHAR_W-1:0] CHAR_STAR = 8'h2A;
    localparam logic [CHAR_W-1:0] CHAR_DOT = 8'h2E;
    typedef enum logic [1:0] {IDLE, LOAD, DROP, COMMIT} bank_state_t;
    typedef struct packed {
        logic [MAX_LEN-1:0][CHAR_W-1:0] chars;
        logic [MAX_LEN-1:0] mask;
        logic [MAX_LEN-1:0] wild;
        logic [LEN_W-1:0] len;
        logic head;
        logic tail;
        logic star_vld;
        logic [LEN_W-1:0] star_idx;
    } pat_t;
endpackage

// File: rtl/pattern_bank_if.sv
// pattern_bank_if: pattern char stream, one char per valid&ready beat
interface pattern_bank_if;
    import sme_pkg::*;
    logic pat_valid;
    logic pat_ready;
    logic [CHAR_W-1:0] pat_data;
    logic pat_last;
    logic [SEL_W-1:0] pat_sel;
    modport master(output pat_valid, pat_data, pat_last, pat_sel, input pat_ready);
    modport slave(input pat_valid, pat_data, pat_last, pat_sel, output pat_ready);
endinterface

// File: rtl/pattern_slot.sv
// pattern_slot: one committed pattern with write-enable, sync clear and parallel read
module pattern_slot
    import sme_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic we,
    input  pat_t wdata,
    output pat_t q,
    output logic vld
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            q <= '0;
            vld <= 1'b0;
        end else if (clr) begin
            q <= '0;
            vld <= 1'b0;
        end else if (we) begin
            q <= wdata;
            vld <= 1'b1;
        end
endmodule

// File: rtl/pattern_bank.sv
// pattern_bank: parses streamed patterns into a shadow buffer and commits them atomically to NUM_PAT slots
module pattern_bank
    import sme_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr_all,
    pattern_bank_if.slave             pat,
    input  logic [SEL_W-1:0]          rd_sel,
    output logic [MAX_LEN*CHAR_W-1:0] rd_chars,
    output logic [MAX_LEN-1:0]        rd_mask,
    output logic [MAX_LEN-1:0]        rd_wild,
    output logic [LEN_W-1:0]          rd_len,
    output logic                      rd_head,
    output logic                      rd_tail,
    output logic                      rd_star_vld,
    output logic [LEN_W-1:0]          rd_star_idx,
    output logic                      rd_vld,
    output logic [NUM_PAT-1:0]        slot_vld,
    output logic                      load_err
);
    bank_state_t state;
    pat_t shadow, base, nxt_sh, rd_q;
    pat_t slot_q [NUM_PAT];
    logic [SEL_W-1:0] wsel;
    logic [LEN_W-1:0] cnt;
    logic ready, acc, first, is_caret, is_dollar, is_star, ovf, err;
    assign pat.pat_ready = ready;
    assign acc = pat.pat_valid & ready;
    assign first = state == IDLE;
    assign base = first ? '0 : shadow;
    assign cnt = base.len;
    assign is_caret = pat.pat_data == CHAR_CARET && cnt == '0 && !base.head;
    assign is_dollar = pat.pat_data == CHAR_DOLLAR && pat.pat_last;
    assign is_star = pat.pat_data == CHAR_STAR;
    assign ovf = !is_caret && !is_dollar && !is_star && cnt == LEN_W'(MAX_LEN);
    assign err = ovf | (is_star & base.star_vld);
    always_comb begin
        nxt_sh = base;
        if (is_caret) nxt_sh.head = 1'b1;
        else if (is_dollar) nxt_sh.tail = 1'b1;
        else if (is_star) begin
            nxt_sh.star_vld = 1'b1;
            nxt_sh.star_idx = cnt;
        end else if (!ovf) begin
            nxt_sh.chars[cnt[IDX_W-1:0]] = pat.pat_data;
            nxt_sh.mask[cnt[IDX_W-1:0]] = 1'b1;
            nxt_sh.wild[cnt[IDX_W-1:0]] = pat.pat_data == CHAR_DOT;
            nxt_sh.len = cnt + 1'b1;
        end
    end
    // An error on the final char skips DROP; load_err is registered so it lands one cycle after that accept
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            shadow <= '0;
            wsel <= '0;
            ready <= 1'b0;
            load_err <= 1'b0;
        end else begin
            load_err <= 1'b0;
            ready <= 1'b1;
            if (clr_all) begin
                state <= IDLE;
                shadow <= '0;
            end else case (state)
                COMMIT: state <= IDLE;
                DROP: if (acc && pat.pat_last) begin
                    state <= IDLE;
                    load_err <= 1'b1;
                end
                default: if (acc) begin
                    shadow <= nxt_sh;
                    if (first) wsel <= pat.pat_sel;
                    state <= err ? (pat.pat_last ? IDLE : DROP) : (pat.pat_last ? COMMIT : LOAD);
                    load_err <= err & pat.pat_last;
                    ready <= err | !pat.pat_last;
                end
            endcase
        end
    for (genvar g = 0; g < NUM_PAT; g++) begin : g_slot
        pattern_slot u_slot (
            .clk(clk),
            .rst_n(rst_n),
            .clr(clr_all),
            .we(state == COMMIT && !clr_all && wsel == SEL_W'(g)),
            .wdata(shadow),
            .q(slot_q[g]),
            .vld(slot_vld[g])
        );
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rd_q <= '0;
            rd_vld <= 1'b0;
        end else begin
            rd_q <= clr_all ? '0 : slot_q[rd_sel];
            rd_vld <= !clr_all && slot_vld[rd_sel];
        end
    assign rd_chars = rd_q.chars;
    assign rd_mask = rd_q.mask;
    assign rd_wild = rd_q.wild;
    assign rd_len = rd_q.len;
    assign rd_head = rd_q.head;
    assign rd_tail = rd_q.tail;
    assign rd_star_vld = rd_q.star_vld;
    assign rd_star_idx = rd_q.star_idx;
endmodule

// File: tb/tb_pattern_bank.sv
// tb_pattern_bank: directed load/commit/error/clear/reset scenarios with hand-computed expectations
module tb_pattern_bank;
    logic clk = 1'b0, rst_n = 1'b0, clr_all = 1'b0;
    logic [1:0] rd_sel = '0;
    logic [63:0] rd_chars;
    logic [7:0] rd_mask, rd_wild;
    logic [3:0] rd_len, rd_star_idx, slot_vld;
    logic rd_head, rd_tail, rd_star_vld, rd_vld, load_err;
    int tests = 0, fails = 0, stall;
    pattern_bank_if bus();
    pattern_bank dut (
        .clk(clk), .rst_n(rst_n), .clr_all(clr_all), .pat(bus), .rd_sel(rd_sel),
        .rd_chars(rd_chars), .rd_mask(rd_mask), .rd_wild(rd_wild), .rd_len(rd_len),
        .rd_head(rd_head), .rd_tail(rd_tail), .rd_star_vld(rd_star_vld), .rd_star_idx(rd_star_idx),
        .rd_vld(rd_vld), .slot_vld(slot_vld), .load_err(load_err)
    );
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // returns the number of cycles the char waited for pat_ready
    task automatic send(input logic [7:0] c, input logic last, input logic [1:0] sel, output int n);
        n = 0;
        bus.pat_valid = 1'b1;
        bus.pat_data = c;
        bus.pat_last = last;
        bus.pat_sel = sel;
        while (!bus.pat_ready && n < 20) begin
            tick(1);
            n++;
        end
        if (n >= 20) chk("ready_timeout", 64'(n), 64'(0));
        tick(1);
        bus.pat_valid = 1'b0;
        bus.pat_last = 1'b0;
    endtask

    task automatic send_str(input string s, input logic [1:0] sel);
        int n;
        for (int i = 0; i < s.len(); i++) send(s[i], i == s.len() - 1, sel, n);
    endtask

    initial begin
        bus.pat_valid = 1'b0;
        bus.pat_data = '0;
        bus.pat_last = 1'b0;
        bus.pat_sel = '0;
        tick(2);
        chk("rst_ready", 64'(bus.pat_ready), 64'(0));
        chk("rst_slot_vld", 64'(slot_vld), 64'(0));
        chk("rst_rd", {rd_chars}, 64'(0));
        chk("rst_misc", 64'({rd_len, rd_vld, load_err, rd_head, rd_tail, rd_star_vld}), 64'(0));
        rst_n = 1'b1;
        tick(1);
        chk("ready_after_rst", 64'(bus.pat_ready), 64'(1));

        rd_sel = 2'd2;
        send_str("ab.c", 2'd2);
        tick(2);
        chk("t1_len", 64'(rd_len), 64'(4));
        chk("t1_mask", 64'(rd_mask), 64'h0F);
        chk("t1_wild", 64'(rd_wild), 64'h04);
        chk("t1_chars", rd_chars, 64'h0000_0000_632E_6261);
        chk("t1_vld", 64'({rd_vld, slot_vld}), 64'h14);

        rd_sel = 2'd0;
        send_str("^ab*cd$", 2'd0);
        tick(2);
        chk("t2_flags", 64'({rd_head, rd_tail, rd_star_vld, rd_star_idx}), 64'b111_0010);
        chk("t2_len", 64'(rd_len), 64'(4));
        chk("t2_chars", rd_chars, 64'h0000_0000_6463_6261);
        chk("t2_wild_mask", 64'({rd_wild, rd_mask}), 64'h000F);

        send_str("xy", 2'd1);
        tick(2);
        chk("slot1_vld", 64'(slot_vld), 64'b0111);

        rd_sel = 2'd3;
        send_str("abcdefghi", 2'd3);
        chk("t3_err_pulse", 64'(load_err), 64'(1));
        tick(1);
        chk("t3_err_end", 64'(load_err), 64'(0));
        tick(2);
        chk("t3_slot_vld", 64'(slot_vld), 64'b0111);
        chk("t3_rd", 64'({rd_vld, rd_len}), 64'(0));

        send_str("a*b*", 2'd1);
        chk("t4_err_pulse", 64'(load_err), 64'(1));
        rd_sel = 2'd1;
        tick(3);
        chk("t4_slot1_chars", rd_chars, 64'h0000_0000_0000_7978);
        chk("t4_slot1_len", 64'({rd_vld, rd_len}), 64'h12);
        chk("t4_err_done", 64'(load_err), 64'(0));

        rd_sel = 2'd3;
        send_str("a^b\044c", 2'd3);
        tick(2);
        chk("t4_lit_chars", rd_chars, 64'h0000_0063_2462_5E61);
        chk("t4_lit_len", 64'({rd_head, rd_tail, rd_len}), 64'h05);
        chk("t4_lit_mask", 64'(rd_mask), 64'h1F);
        chk("t4_slot_vld", 64'(slot_vld), 64'hF);

        send("p", 1'b0, 2'd0, stall);
        send("q", 1'b1, 2'd0, stall);
        send("r", 1'b0, 2'd3, stall);
        chk("t5_commit_stall", 64'(stall), 64'(1));
        send("s", 1'b1, 2'd3, stall);
        chk("t5_no_stall", 64'(stall), 64'(0));
        tick(2);
        chk("t5_slot3", 64'({rd_len, rd_chars[31:0]}), 64'h2_0000_7372);
        rd_sel = 2'd0;
        tick(1);
        chk("t5_slot0", 64'({rd_len, rd_chars[31:0]}), 64'h2_0000_7170);

        rd_sel = 2'd3;
        send_str("ab", 2'd2);
        tick(1);
        chk("t6_pre_clr_vld", 64'(rd_vld), 64'(1));
        send_str("ab", 2'd2);
        bus.pat_valid = 1'b1;
        bus.pat_data = "z";
        bus.pat_last = 1'b1;
        bus.pat_sel = 2'd2;
        clr_all = 1'b1;
        tick(1);
        clr_all = 1'b0;
        bus.pat_valid = 1'b0;
        bus.pat_last = 1'b0;
        chk("t6_rd_vld_clr", 64'(rd_vld), 64'(0));
        chk("t6_slot_vld_clr", 64'(slot_vld), 64'(0));
        tick(3);
        chk("t6_no_commit", 64'({slot_vld, rd_len}), 64'(0));
        rd_sel = 2'd1;
        send_str("k", 2'd1);
        tick(2);
        chk("t6_idle_after_clr", 64'(slot_vld), 64'b0010);
        chk("t6_k_chars", rd_chars, 64'h6B);

        send("m", 1'b0, 2'd0, stall);
        send("n", 1'b0, 2'd0, stall);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ready", 64'(bus.pat_ready), 64'(0));
        chk("t6_rst_vld", 64'({slot_vld, rd_vld}), 64'(0));
        tick(1);
        rst_n = 1'b1;
        tick(3);
        chk("t6_rst_no_commit", 64'(slot_vld), 64'(0));
        send_str("z", 2'd2);
        tick(2);
        chk("t6_idle_after_rst", 64'(slot_vld), 64'b0100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
